// File: rtl/mul_err_monitor.sv
// LFSR-driven stimulus and error-statistics engine for a combinational 16x16 multiplier under test.
// Optional worst-case tracking (max_err/max_a/max_b) is enabled by defining MUL_ERR_MON_MAXERR_EN.
module mul_err_monitor #(
   parameter int          WIDTH       = 16,
   parameter int          NUM_VECTORS = 1000,
   parameter logic [31:0] SEED        = 32'hACE1_2024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [WIDTH-1:0]     op_a,
   output logic [WIDTH-1:0]     op_b,
   input  logic [2*WIDTH-1:0]   approx_c,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          mismatch_count,
   output logic [47:0]          err_sum
`ifdef MUL_ERR_MON_MAXERR_EN
   ,
   output logic [2*WIDTH-1:0]   max_err,
   output logic [WIDTH-1:0]     max_a,
   output logic [WIDTH-1:0]     max_b
`endif
);

   localparam int          PW       = 2 * WIDTH;
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
   localparam logic [15:0] N_LAST   = 16'(NUM_VECTORS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   // Fibonacci LFSR, taps 32,22,2,1, shifting left with feedback into bit 0.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   state_t             state_q, state_d;
   logic [31:0]        lfsr_q, lfsr_d;
   logic [15:0]        vec_cnt_q, vec_cnt_d;
   logic               drain_q, drain_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic               clear_stats;

   logic [WIDTH-1:0]   s1_a_q, s1_a_d;
   logic [WIDTH-1:0]   s1_b_q, s1_b_d;
   logic [PW-1:0]      s1_c_q, s1_c_d;
   logic               s1_vld_q, s1_vld_d;

   logic [PW-1:0]      s2_exact_q, s2_exact_d;
   logic [PW-1:0]      s2_diff_q, s2_diff_d;
   logic               s2_mis_q, s2_mis_d;
   logic               s2_vld_q, s2_vld_d;
   logic [WIDTH-1:0]   s2_a_q, s2_a_d;
   logic [WIDTH-1:0]   s2_b_q, s2_b_d;

   logic [15:0]        mis_cnt_q, mis_cnt_d;
   logic [47:0]        err_sum_q, err_sum_d;
`ifdef MUL_ERR_MON_MAXERR_EN
   logic [PW-1:0]      max_err_q, max_err_d;
   logic [WIDTH-1:0]   max_a_q, max_a_d;
   logic [WIDTH-1:0]   max_b_q, max_b_d;
`endif

   // Sequencer: vector 1 comes straight from SEED in the accept cycle, later ones from the LFSR.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      vec_cnt_d   = vec_cnt_q;
      drain_d     = drain_q;
      op_a_d      = '0;
      op_b_d      = '0;
      clear_stats = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               clear_stats = 1'b1;
               op_a_d      = SEED_EFF[16 +: WIDTH];
               op_b_d      = SEED_EFF[0 +: WIDTH];
               lfsr_d      = lfsr_step(SEED_EFF);
               vec_cnt_d   = 16'd1;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            if (vec_cnt_q == N_LAST) begin
               drain_d = 1'b0;
               state_d = S_DRAIN;
            end else begin
               op_a_d    = lfsr_q[16 +: WIDTH];
               op_b_d    = lfsr_q[0 +: WIDTH];
               lfsr_d    = lfsr_step(lfsr_q);
               vec_cnt_d = vec_cnt_q + 16'd1;
            end
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      s1_vld_d = (state_q == S_RUN);
      s1_a_d   = op_a_q;
      s1_b_d   = op_b_q;
      s1_c_d   = approx_c;
   end

   always_comb begin
      s2_vld_d   = s1_vld_q;
      s2_a_d     = s1_a_q;
      s2_b_d     = s1_b_q;
      s2_exact_d = PW'(s1_a_q) * PW'(s1_b_q);
      s2_diff_d  = (s2_exact_d >= s1_c_q) ? (s2_exact_d - s1_c_q) : (s1_c_q - s2_exact_d);
      s2_mis_d   = (s2_exact_d != s1_c_q);
   end

   always_comb begin
      mis_cnt_d = mis_cnt_q;
      err_sum_d = err_sum_q;
`ifdef MUL_ERR_MON_MAXERR_EN
      max_err_d = max_err_q;
      max_a_d   = max_a_q;
      max_b_d   = max_b_q;
`endif
      if (clear_stats) begin
         mis_cnt_d = '0;
         err_sum_d = '0;
`ifdef MUL_ERR_MON_MAXERR_EN
         max_err_d = '0;
         max_a_d   = '0;
         max_b_d   = '0;
`endif
      end else if (s2_vld_q) begin
         if (s2_mis_q && (mis_cnt_q != 16'hFFFF)) begin
            mis_cnt_d = mis_cnt_q + 16'd1;
         end
         err_sum_d = err_sum_q + 48'(s2_diff_q);
`ifdef MUL_ERR_MON_MAXERR_EN
         // Strictly greater keeps the first vector that reached the worst error.
         if (s2_diff_q > max_err_q) begin
            max_err_d = s2_diff_q;
            max_a_d   = s2_a_q;
            max_b_d   = s2_b_q;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lfsr_q     <= '0;
         vec_cnt_q  <= '0;
         drain_q    <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_c_q     <= '0;
         s1_vld_q   <= 1'b0;
         s2_exact_q <= '0;
         s2_diff_q  <= '0;
         s2_mis_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_a_q     <= '0;
         s2_b_q     <= '0;
         mis_cnt_q  <= '0;
         err_sum_q  <= '0;
`ifdef MUL_ERR_MON_MAXERR_EN
         max_err_q  <= '0;
         max_a_q    <= '0;
         max_b_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         vec_cnt_q  <= vec_cnt_d;
         drain_q    <= drain_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_c_q     <= s1_c_d;
         s1_vld_q   <= s1_vld_d;
         s2_exact_q <= s2_exact_d;
         s2_diff_q  <= s2_diff_d;
         s2_mis_q   <= s2_mis_d;
         s2_vld_q   <= s2_vld_d;
         s2_a_q     <= s2_a_d;
         s2_b_q     <= s2_b_d;
         mis_cnt_q  <= mis_cnt_d;
         err_sum_q  <= err_sum_d;
`ifdef MUL_ERR_MON_MAXERR_EN
         max_err_q  <= max_err_d;
         max_a_q    <= max_a_d;
         max_b_q    <= max_b_d;
`endif
      end
   end

   assign op_a           = op_a_q;
   assign op_b           = op_b_q;
   assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done           = (state_q == S_DONE);
   assign mismatch_count = mis_cnt_q;
   assign err_sum        = err_sum_q;
`ifdef MUL_ERR_MON_MAXERR_EN
   assign max_err        = max_err_q;
   assign max_a          = max_a_q;
   assign max_b          = max_b_q;
`endif

endmodule
